// File: rtl/reset_sequencer.sv
// Generates the core's active-low reset from block reset, debounced push-button and watchdog.
// Define RSTSEQ_WDOG_EN to enable the watchdog timeout path.
module reset_sequencer #(
   parameter int SYNC_STAGES = 2,
   parameter int DEBOUNCE    = 1000,
   parameter int HOLD        = 16,
   parameter int WDOG_CYCLES = 1048576
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       btn,
   input  logic       kick,
   output logic       resetn,
   output logic       busy,
   output logic [1:0] rst_cause,
   output logic [7:0] rst_count
);
   localparam int HW = $clog2(HOLD + 1);
   localparam int DW = $clog2(DEBOUNCE + 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);
   localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE - 1);

   localparam logic [1:0] S_HOLD    = 2'd0;
   localparam logic [1:0] S_RUN     = 2'd1;
   localparam logic [1:0] S_PRESSED = 2'd2;

   localparam logic [1:0] C_BLOCK = 2'b00;
   localparam logic [1:0] C_BTN   = 2'b01;
   localparam logic [1:0] C_WDOG  = 2'b10;

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_btn_db;
   logic [DW-1:0]          r_deb_cnt;
   logic [1:0]             r_state;
   logic [HW-1:0]          r_hold_cnt;

   logic                   w_btn_s;
   logic                   w_wd_fire;
   logic [1:0]             w_state_nxt;
   logic [HW-1:0]          w_hold_nxt;
   logic                   w_exit;
   logic [1:0]             w_cause_nxt;

   assign w_btn_s = r_sync[SYNC_STAGES-1];

   // Level change is accepted only after DEBOUNCE consecutive differing samples.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_sync    <= '0;
         r_btn_db  <= 1'b0;
         r_deb_cnt <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], btn};
         if (w_btn_s == r_btn_db) begin
            r_deb_cnt <= '0;
         end else if (r_deb_cnt == DEB_LAST) begin
            r_btn_db  <= w_btn_s;
            r_deb_cnt <= '0;
         end else begin
            r_deb_cnt <= r_deb_cnt + 1'b1;
         end
      end
   end

`ifdef RSTSEQ_WDOG_EN
   localparam int WW = $clog2(WDOG_CYCLES + 1);
   localparam logic [WW-1:0] WD_LAST = WW'(WDOG_CYCLES - 1);

   logic [WW-1:0] r_wd_cnt;

   // A kick on the terminal cycle suppresses the timeout.
   assign w_wd_fire = (r_state == S_RUN) && !kick && (r_wd_cnt == WD_LAST);

   always_ff @(posedge CLK) begin
      if (RESET || (r_state != S_RUN) || kick || w_wd_fire) begin
         r_wd_cnt <= '0;
      end else begin
         r_wd_cnt <= r_wd_cnt + 1'b1;
      end
   end
`else
   logic w_unused_kick;
   assign w_unused_kick = kick;
   assign w_wd_fire     = 1'b0;
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_hold_nxt  = r_hold_cnt;
      w_exit      = 1'b0;
      w_cause_nxt = rst_cause;
      case (r_state)
         S_HOLD: begin
            if (r_btn_db) begin
               w_state_nxt = S_PRESSED;
               w_hold_nxt  = '0;
            end else if (r_hold_cnt == HOLD_LAST) begin
               w_state_nxt = S_RUN;
               w_hold_nxt  = '0;
            end else begin
               w_hold_nxt  = r_hold_cnt + 1'b1;
            end
         end
         S_RUN: begin
            // Button outranks a simultaneous watchdog timeout.
            if (r_btn_db) begin
               w_state_nxt = S_PRESSED;
               w_exit      = 1'b1;
               w_cause_nxt = C_BTN;
            end else if (w_wd_fire) begin
               w_state_nxt = S_HOLD;
               w_hold_nxt  = '0;
               w_exit      = 1'b1;
               w_cause_nxt = C_WDOG;
            end
         end
         S_PRESSED: begin
            if (!r_btn_db) begin
               w_state_nxt = S_HOLD;
               w_hold_nxt  = '0;
            end
         end
         default: begin
            w_state_nxt = S_HOLD;
            w_hold_nxt  = '0;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_state    <= S_HOLD;
         r_hold_cnt <= '0;
         resetn     <= 1'b0;
         busy       <= 1'b1;
         rst_cause  <= C_BLOCK;
         rst_count  <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_hold_cnt <= w_hold_nxt;
         resetn     <= (w_state_nxt == S_RUN);
         busy       <= (w_state_nxt != S_RUN);
         rst_cause  <= w_cause_nxt;
         if (w_exit && (rst_count != 8'hFF)) begin
            rst_count <= rst_count + 8'd1;
         end
      end
   end
endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Produces the SoC-wide active-low reset `resetn` consumed alongside the divided clock.
- Holds the core in reset for a programmed number of cycles after block reset and after every debounced push-button press.
- Optionally also after a watchdog timeout.
- Reports reset cause and a saturating reset count for debug LEDs/UART.

Parameters:
SYNC_STAGES, 2, number of synchronizer flops on async button input (>=2)
DEBOUNCE, 1000, consecutive stable cycles required to accept a button level change (>=1)
HOLD, 16, cycles resetn stays low after button release / block reset (>=1)
WDOG_CYCLES, 1048576, watchdog timeout in cycles (>=2; used only with watchdog)

Ports:
CLK  input  1  system clock; all logic on posedge
RESET  input  1  synchronous active-high block reset
btn  input  1  asynchronous raw push-button, active-high
kick  input  1  watchdog kick pulse from core, synchronous to CLK
resetn  output  1  registered active-low reset to the core
busy  output  1  high whenever state != RUN
rst_cause  output  2  cause of most recent reset: 00 block reset, 01 button, 10 watchdog, 11 unused
rst_count  output  8  number of RUN-to-reset entries since RESET, saturating at 255

Behaviour:
- Clocking and reset: one clock `CLK`; reset `RESET` is synchronous, active-high.
- RESET=1 at an edge:
  - state<=HOLD, hold_cnt<=0, sync flops<=0, btn_db<=0, deb_cnt<=0, wd_cnt<=0.
  - resetn<=0, busy<=1, rst_cause<=00, rst_count<=0.
  - RESET overrides every other event, including mid-HOLD or mid-PRESSED.
- Synchronizer: btn passes through SYNC_STAGES flops -> btn_s.
- Debounce:
  - btn_s==btn_db: deb_cnt<=0.
  - btn_s!=btn_db: deb_cnt increments.
  - When deb_cnt==DEBOUNCE-1 and still differing: btn_db<=btn_s, deb_cnt<=0.
  - A glitch shorter than DEBOUNCE cycles never changes btn_db.
- FSM (states HOLD, RUN, PRESSED):
  - HOLD:
    - resetn=0. hold_cnt increments each cycle.
    - btn_db==1 -> PRESSED, hold_cnt<=0.
    - Else if hold_cnt==HOLD-1 -> RUN.
    - Button takes priority over hold expiry.
  - RUN:
    - resetn=1.
    - btn_db==1 -> PRESSED, rst_cause<=01, rst_count+=1 (saturating).
  - PRESSED:
    - resetn=0, for as long as btn_db==1.
    - btn_db==0 -> HOLD, hold_cnt<=0.
- Outputs:
  - resetn and busy are registered from next-state.
  - resetn changes on the same edge the state changes.
- Latency:
  - btn rising and held stable from edge 0 -> resetn low after edge SYNC_STAGES+DEBOUNCE+1.
  - Release -> resetn high after HOLD further cycles beyond the debounced release.
- Timing after block reset: RESET deasserted, button idle -> resetn rises exactly HOLD edges after the first edge with RESET=0.
- rst_count: increments only on RUN->non-RUN transitions; holds at 255.
- rst_cause: written only on RUN exit; otherwise held.

Optional Feature:
- Macro: RSTSEQ_WDOG_EN.
- Defined:
  - wd_cnt increments each cycle in RUN.
  - wd_cnt clears on kick=1 or whenever state!=RUN.
  - When wd_cnt==WDOG_CYCLES-1 and kick==0: state<=HOLD, hold_cnt<=0, rst_cause<=10, rst_count+=1.
  - Kick and timeout on the same cycle: kick wins.
  - Button and timeout on the same cycle: button wins (cause 01, state PRESSED).
- Undefined:
  - No wd_cnt logic; kick ignored.
  - rst_cause never 10.

Test Plan (SYNC_STAGES=2, DEBOUNCE=4, HOLD=16, WDOG_CYCLES=64):
- Power-up: RESET high 3 cycles then low, btn=0 -> resetn=0 for 16 edges then 1; busy mirrors; rst_cause=00, rst_count=0.
- Clean press: in RUN, btn high for 20 cycles then low -> resetn falls 7 edges after press, stays low while debounced high, rises 16 cycles after debounced release; rst_cause=01, rst_count=1.
- Glitch: in RUN, btn pulses high 3 cycles -> resetn stays 1, rst_count unchanged.
- Press during HOLD: btn asserted during post-reset hold -> PRESSED, rst_count unchanged, full 16-cycle hold restarts after release.
- Saturation/mid-op reset: 260 press cycles -> rst_count=255; RESET pulse while PRESSED -> resetn=0, rst_count=0, rst_cause=00, HOLD restarts.
- Watchdog (RSTSEQ_WDOG_EN): no kick for 64 RUN cycles -> resetn low, rst_cause=10; kick every 50 cycles -> no reset; kick on timeout cycle -> no reset.
